// File: rtl/tlc_junction_ctrl.sv
// Junction phase sequencer: main road, side road and a pedestrian crossing.
// Main road rests on green. Side-road and pedestrian requests are latched
// and served in a fixed rotation: main -> (walk) -> (side) -> main.
// Optional feature macro: EMERGENCY_PREEMPT_EN adds an 'emerg' input that
// holds main green and truncates side green / pedestrian walk.
module tlc_junction_ctrl #(
  parameter int CNT_W        = 8,
  parameter int T_MAIN_GREEN = 20,
  parameter int T_SIDE_GREEN = 10,
  parameter int T_YELLOW     = 3,
  parameter int T_ALL_RED    = 1,
  parameter int T_WALK       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_sensor,
  input  logic       ped_req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emerg,
`endif
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALL_RED_M   = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALL_RED_S   = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    PED_WALK    = 3'd6
  } state_e;

  // Timer reload values: a state lasting N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] LD_MAIN_GREEN = CNT_W'(T_MAIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_SIDE_GREEN = CNT_W'(T_SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW     = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALL_RED    = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LD_WALK       = CNT_W'(T_WALK - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             side_pend_q, side_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_ack_q, ped_ack_d;

  logic emerg_w;
  logic expired;
  logic entering;
  logic side_pend_set;
  logic ped_pend_set;

`ifdef EMERGENCY_PREEMPT_EN
  assign emerg_w = emerg;
`else
  assign emerg_w = 1'b0;
`endif

  assign expired = (timer_q == '0);

  // A request seen this cycle already counts as pending, so a request that
  // arrives after main-green expiry leaves main green on the next cycle.
  assign side_pend_set = side_pend_q | (side_sensor & (state_q != SIDE_GREEN));
  assign ped_pend_set  = ped_pend_q  | (ped_req     & (state_q != PED_WALK));

  function automatic logic [CNT_W-1:0] load_val(input state_e s);
    case (s)
      MAIN_GREEN:              load_val = LD_MAIN_GREEN;
      SIDE_GREEN:              load_val = LD_SIDE_GREEN;
      MAIN_YELLOW,SIDE_YELLOW: load_val = LD_YELLOW;
      PED_WALK:                load_val = LD_WALK;
      default:                 load_val = LD_ALL_RED;
    endcase
  endfunction

  // State, timer, request latches and ack pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ALL_RED_M;
      timer_q     <= LD_ALL_RED;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      ped_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      ped_ack_q   <= ped_ack_d;
    end
  end

  // Next-state: phase rotation, with emergency hold/truncation when enabled
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALL_RED_M:   if (expired) state_d = MAIN_GREEN;
      MAIN_GREEN:  if (expired && !emerg_w && (side_pend_set || ped_pend_set))
                     state_d = MAIN_YELLOW;
      MAIN_YELLOW: if (expired) state_d = ALL_RED_S;
      ALL_RED_S:   if (expired) begin
                     if (ped_pend_set)       state_d = PED_WALK;
                     else if (side_pend_set) state_d = SIDE_GREEN;
                     else                    state_d = ALL_RED_M;
                   end
      SIDE_GREEN:  if (expired || emerg_w) state_d = SIDE_YELLOW;
      SIDE_YELLOW: if (expired) state_d = ALL_RED_M;
      PED_WALK:    if (emerg_w)      state_d = ALL_RED_M;
                   else if (expired) state_d = side_pend_set ? SIDE_GREEN : ALL_RED_M;
      default:     state_d = ALL_RED_M;
    endcase
  end

  // Timer reload on entry, saturating countdown otherwise; request clears on service
  always_comb begin
    entering = (state_d != state_q);
    timer_d  = timer_q;
    if (entering)     timer_d = load_val(state_d);
    else if (!expired) timer_d = timer_q - CNT_W'(1);
    side_pend_d = side_pend_set;
    ped_pend_d  = ped_pend_set;
    ped_ack_d   = 1'b0;
    if (entering && state_d == SIDE_GREEN) side_pend_d = 1'b0;
    if (entering && state_d == PED_WALK) begin
      ped_pend_d = 1'b0;
      ped_ack_d  = 1'b1;
    end
  end

  // Moore lamp decode: one lamp per road, red unless that road is served
  always_comb begin
    main_red    = 1'b1;
    main_yellow = 1'b0;
    main_green  = 1'b0;
    side_red    = 1'b1;
    side_yellow = 1'b0;
    side_green  = 1'b0;
    walk        = 1'b0;
    case (state_q)
      MAIN_GREEN:  begin main_red = 1'b0; main_green  = 1'b1; end
      MAIN_YELLOW: begin main_red = 1'b0; main_yellow = 1'b1; end
      SIDE_GREEN:  begin side_red = 1'b0; side_green  = 1'b1; end
      SIDE_YELLOW: begin side_red = 1'b0; side_yellow = 1'b1; end
      PED_WALK:    walk = 1'b1;
      default:     ;
    endcase
  end

  assign ped_ack = ped_ack_q;
  assign phase   = state_q;

endmodule

// File: tb/tb_tlc_junction_ctrl.sv
// Self-checking bench for tlc_junction_ctrl: directed scenarios plus a
// randomized run, all compared against a time-in-phase reference model.
module tb_tlc_junction_ctrl;
  localparam int T_MG = 20, T_SG = 10, T_Y = 3, T_AR = 1, T_W = 8;

  logic clk = 1'b0, rst = 1'b1, side_sensor = 1'b0, ped_req = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
  logic emerg = 1'b0;
`endif
  logic main_red, main_yellow, main_green, side_red, side_yellow, side_green;
  logic walk, ped_ack;
  logic [2:0] phase;

  tlc_junction_ctrl #(.CNT_W(8), .T_MAIN_GREEN(T_MG), .T_SIDE_GREEN(T_SG),
                      .T_YELLOW(T_Y), .T_ALL_RED(T_AR), .T_WALK(T_W)) dut (
    .clk(clk), .rst(rst), .side_sensor(side_sensor), .ped_req(ped_req),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg(emerg),
`endif
    .main_red(main_red), .main_yellow(main_yellow), .main_green(main_green),
    .side_red(side_red), .side_yellow(side_yellow), .side_green(side_green),
    .walk(walk), .ped_ack(ped_ack), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  localparam logic [10:0] RST_VEC = 11'b000_1001_0000;

  // Reference model: phase, cycles spent in it, outstanding requests
  int m_ph, m_el;
  bit m_sp, m_pp, m_ack;
  int hist[$];
  int rph[$], rln[$];

  logic [10:0] dut_vec;
  assign dut_vec = {phase, main_red, main_yellow, main_green,
                    side_red, side_yellow, side_green, walk, ped_ack};

  function automatic int dur(input int p);
    case (p)
      1: return T_MG;
      2, 5: return T_Y;
      4: return T_SG;
      6: return T_W;
      default: return T_AR;
    endcase
  endfunction

  function automatic logic [10:0] exp_vec();
    logic mg, my, sg, sy;
    mg = (m_ph == 1); my = (m_ph == 2); sg = (m_ph == 4); sy = (m_ph == 5);
    return {3'(m_ph), !(mg || my), my, mg, !(sg || sy), sy, sg, (m_ph == 6), m_ack};
  endfunction

  function automatic void model_step(input bit r, input bit si, input bit pi, input bit e);
    bit done, sp, pp;
    int nxt;
    if (r) begin
      m_ph = 0; m_el = 0; m_sp = 0; m_pp = 0; m_ack = 0;
      return;
    end
    done = (m_el + 1 >= dur(m_ph));
    sp = m_sp || (si && m_ph != 4);
    pp = m_pp || (pi && m_ph != 6);
    nxt = m_ph;
    if (m_ph == 0 && done) nxt = 1;
    if (m_ph == 1 && done && !e && (sp || pp)) nxt = 2;
    if (m_ph == 2 && done) nxt = 3;
    if (m_ph == 3 && done) nxt = pp ? 6 : (sp ? 4 : 0);
    if (m_ph == 4 && (done || e)) nxt = 5;
    if (m_ph == 5 && done) nxt = 0;
    if (m_ph == 6 && e) nxt = 0;
    else if (m_ph == 6 && done) nxt = sp ? 4 : 0;
    m_ack = (nxt != m_ph) && nxt == 6;
    if (nxt != m_ph && nxt == 4) sp = 0;
    if (nxt != m_ph && nxt == 6) pp = 0;
    m_el = (nxt != m_ph) ? 0 : m_el + 1;
    m_ph = nxt; m_sp = sp; m_pp = pp;
  endfunction

  // One clock: model sees the same inputs the DUT samples; outputs settle by +1
  task automatic tick();
    bit e = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
    e = emerg;
`endif
    @(posedge clk);
    model_step(rst, side_sensor, ped_req, e);
    #1;
    hist.push_back(int'(phase));
  endtask

  function automatic void compute_runs();
    rph.delete(); rln.delete();
    foreach (hist[i]) begin
      if (rph.size() == 0 || rph[rph.size()-1] != hist[i]) begin
        rph.push_back(hist[i]); rln.push_back(1);
      end else rln[rln.size()-1] = rln[rln.size()-1] + 1;
    end
  endfunction

  task automatic test_reset();
    rst = 1; side_sensor = 1; ped_req = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== RST_VEC) begin
        n_err++; $display("FAIL reset_state cyc%0d got %b exp %b", i, dut_vec, RST_VEC);
      end
    end
    rst = 0; side_sensor = 0; ped_req = 0;
  endtask

  task automatic test_idle();
    int n_mg = 0, n_ack = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL idle_model cyc%0d got %b exp %b", i, dut_vec, exp_vec());
      end
      if (phase == 3'd1 && main_green && side_red) n_mg++;
      if (ped_ack) n_ack++;
    end
    n_checks++;
    if (n_mg !== 100) begin n_err++; $display("FAIL idle_hold got %0d exp 100", n_mg); end
    n_checks++;
    if (n_ack !== 0) begin n_err++; $display("FAIL idle_ack got %0d exp 0", n_ack); end
  endtask

  task automatic test_side();
    int ep[$], el[$];
    ep = '{1, 2, 3, 4, 5, 0, 1}; el = '{20, 3, 1, 10, 3, 1, 22};
    rst = 1; tick(); rst = 0;
    hist.delete();
    for (int i = 0; i < 60; i++) begin
      side_sensor = (i == 5);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL side_model cyc%0d got %b exp %b", i, dut_vec, exp_vec());
      end
    end
    side_sensor = 0;
    compute_runs();
    n_checks++;
    if (rph.size() !== ep.size()) begin
      n_err++; $display("FAIL side_runs count got %0d exp %0d", rph.size(), ep.size());
    end
    for (int k = 0; k < ep.size() && k < rph.size(); k++) begin
      n_checks++;
      if (rph[k] !== ep[k] || rln[k] !== el[k]) begin
        n_err++; $display("FAIL side_run%0d got ph%0d x%0d exp ph%0d x%0d", k, rph[k], rln[k], ep[k], el[k]);
      end
    end
  endtask

  task automatic test_ped();
    int ep[$], el[$];
    int n_ack = 0, ack_at = -1;
    ep = '{2, 3, 6, 0, 1}; el = '{3, 1, 8, 1, 17};
    hist.delete();
    for (int i = 0; i < 30; i++) begin
      ped_req = (i == 0);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL ped_model cyc%0d got %b exp %b", i, dut_vec, exp_vec());
      end
      if (ped_ack) begin n_ack++; ack_at = i; end
    end
    ped_req = 0;
    n_checks++;
    if (n_ack !== 1 || ack_at !== 4) begin
      n_err++; $display("FAIL ped_ack got %0d pulses at %0d exp 1 at 4", n_ack, ack_at);
    end
    compute_runs();
    n_checks++;
    if (rph.size() !== ep.size()) begin
      n_err++; $display("FAIL ped_runs count got %0d exp %0d", rph.size(), ep.size());
    end
    for (int k = 0; k < ep.size() && k < rph.size(); k++) begin
      n_checks++;
      if (rph[k] !== ep[k] || rln[k] !== el[k]) begin
        n_err++; $display("FAIL ped_run%0d got ph%0d x%0d exp ph%0d x%0d", k, rph[k], rln[k], ep[k], el[k]);
      end
    end
  endtask

  task automatic test_both();
    int ep[$], el[$];
    ep = '{2, 3, 6, 4, 5, 0, 1, 2, 3, 6, 0, 1};
    el = '{3, 1, 8, 10, 3, 1, 20, 3, 1, 8, 1, 21};
    repeat (5) tick();
    hist.delete();
    for (int i = 0; i < 80; i++) begin
      side_sensor = (i == 0);
      ped_req = (i == 0 || i == 14);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL both_model cyc%0d got %b exp %b", i, dut_vec, exp_vec());
      end
    end
    side_sensor = 0; ped_req = 0;
    compute_runs();
    n_checks++;
    if (rph.size() !== ep.size()) begin
      n_err++; $display("FAIL both_runs count got %0d exp %0d", rph.size(), ep.size());
    end
    for (int k = 0; k < ep.size() && k < rph.size(); k++) begin
      n_checks++;
      if (rph[k] !== ep[k] || rln[k] !== el[k]) begin
        n_err++; $display("FAIL both_run%0d got ph%0d x%0d exp ph%0d x%0d", k, rph[k], rln[k], ep[k], el[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_mg = 0;
    bit found = 0;
    side_sensor = 1;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      side_sensor = 0;
      if (m_ph == 4 && m_el == 3) found = 1;
    end
    n_checks++;
    if (!found || phase !== 3'd4) begin
      n_err++; $display("FAIL rstmid_reach got phase %0d exp 4 (found=%0d)", phase, found);
    end
    rst = 1; side_sensor = 1;
    tick();
    n_checks++;
    if (dut_vec !== RST_VEC) begin
      n_err++; $display("FAIL rstmid_state got %b exp %b", dut_vec, RST_VEC);
    end
    rst = 0; side_sensor = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL rstmid_model cyc%0d got %b exp %b", i, dut_vec, exp_vec());
      end
      if (phase == 3'd1) n_mg++;
    end
    n_checks++;
    if (n_mg !== 40) begin n_err++; $display("FAIL rstmid_hold got %0d exp 40", n_mg); end
  endtask

`ifdef EMERGENCY_PREEMPT_EN
  task automatic test_emerg();
    int ep[$], el[$];
    ep = '{2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1};
    el = '{3, 1, 2, 3, 1, 40, 3, 1, 10, 3, 1, 12};
    hist.delete();
    for (int i = 0; i < 80; i++) begin
      side_sensor = (i == 0 || i == 8);
      emerg = (i >= 6 && i < 50);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL emerg_model cyc%0d got %b exp %b", i, dut_vec, exp_vec());
      end
    end
    side_sensor = 0; emerg = 0;
    compute_runs();
    n_checks++;
    if (rph.size() !== ep.size()) begin
      n_err++; $display("FAIL emerg_runs count got %0d exp %0d", rph.size(), ep.size());
    end
    for (int k = 0; k < ep.size() && k < rph.size(); k++) begin
      n_checks++;
      if (rph[k] !== ep[k] || rln[k] !== el[k]) begin
        n_err++; $display("FAIL emerg_run%0d got ph%0d x%0d exp ph%0d x%0d", k, rph[k], rln[k], ep[k], el[k]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      side_sensor = ($urandom_range(15) == 0);
      ped_req     = ($urandom_range(19) == 0);
      rst         = ($urandom_range(199) == 0);
`ifdef EMERGENCY_PREEMPT_EN
      if ($urandom_range(29) == 0) emerg = ~emerg;
`endif
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL rand_model cyc%0d got %b exp %b", i, dut_vec, exp_vec());
      end
      n_checks++;
      if ((main_green || main_yellow) && (side_green || side_yellow || walk)) begin
        n_err++; $display("FAIL rand_conflict cyc%0d got %b exp no conflict", i, dut_vec);
      end
    end
    rst = 0; side_sensor = 0; ped_req = 0;
`ifdef EMERGENCY_PREEMPT_EN
    emerg = 0;
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_idle();
    test_side();
    test_ped();
    test_both();
    test_reset_mid();
`ifdef EMERGENCY_PREEMPT_EN
    test_emerg();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/tlc_junction_ctrl.md
Name: tlc_junction_ctrl

Overview:
Phase sequencer for a two-road junction (main road, side road) with a pedestrian crossing. It drives two red/yellow/green light sets and a walk signal. Phase durations are set by parameters and counted by an internal timer. Main road rests on green; side-road vehicle-sensor and pedestrian-button requests are latched and served in a fixed rotation.

Parameters:
CNT_W, 8, timer width in bits; every T_* value must be ≤ 2^CNT_W.
T_MAIN_GREEN, 20, minimum main-green duration in cycles (≥1).
T_SIDE_GREEN, 10, side-green duration in cycles (≥1).
T_YELLOW, 3, yellow duration for either road in cycles (≥1).
T_ALL_RED, 1, all-red clearance duration in cycles (≥1).
T_WALK, 8, pedestrian walk duration in cycles (≥1).

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
side_sensor  input  1  side-road vehicle present (level, sampled every cycle)
ped_req  input  1  pedestrian button (level or pulse, sampled every cycle)
main_red / main_yellow / main_green  output  1 each  main-road lamps
side_red / side_yellow / side_green  output  1 each  side-road lamps
walk  output  1  pedestrian walk lamp
ped_ack  output  1  one-cycle pulse when a pedestrian request is served
phase  output  3  current state encoding (debug/status)

Behaviour:
- States and phase encoding: ALL_RED_M=0, MAIN_GREEN=1, MAIN_YELLOW=2, ALL_RED_S=3, SIDE_GREEN=4, SIDE_YELLOW=5, PED_WALK=6. Code 7 is illegal and goes to ALL_RED_M on the next cycle.
- Lamp outputs are Moore outputs decoded from the state register.
  - Exactly one lamp per road is lit.
  - walk=1 only in PED_WALK.
  - Both roads show red in ALL_RED_M, ALL_RED_S and PED_WALK.
- Reset values:
  - state=ALL_RED_M; timer loaded with T_ALL_RED-1.
  - side_pend=0, ped_pend=0, ped_ack=0.
  - Outputs during reset: main_red=side_red=1, all other lamps and walk=0, phase=0.
- Timer: on entry to a state, load duration-1, then decrement once per cycle. The state lasts exactly its duration in cycles. The state's "expired" condition is timer==0.
- Transitions:
  - ALL_RED_M expired -> MAIN_GREEN.
  - MAIN_GREEN:
    - expired and (side_pend or ped_pend) -> MAIN_YELLOW.
    - Otherwise hold; once expired the timer stays at 0.
    - A request arriving after expiry leaves MAIN_GREEN on the next cycle.
  - MAIN_YELLOW expired -> ALL_RED_S.
  - ALL_RED_S expired:
    - ped_pend -> PED_WALK.
    - else side_pend -> SIDE_GREEN.
    - else (unreachable) -> ALL_RED_M.
  - PED_WALK expired: side_pend -> SIDE_GREEN, else -> ALL_RED_M.
  - SIDE_GREEN expired -> SIDE_YELLOW.
  - SIDE_YELLOW expired -> ALL_RED_M.
- side_pend:
  - Set when side_sensor=1 in any state except SIDE_GREEN.
  - Cleared on the cycle SIDE_GREEN is entered.
  - If side_sensor=1 on the entry cycle, clear wins: the request is treated as served.
- ped_pend:
  - Set when ped_req=1 in any state except PED_WALK.
  - Cleared on entry to PED_WALK; clear wins on the entry cycle.
- ped_ack: registered; high for exactly the first cycle of PED_WALK.
- Vehicles never see green on both roads. Every green→other-road-green path passes through yellow then all-red.
- Reset asserted mid-phase: the next cycle is ALL_RED_M with pending flags cleared, regardless of the current state.

Optional Feature:
Macro: EMERGENCY_PREEMPT_EN.

Defined:
- Extra input port `emerg` (1 bit).
- While emerg=1:
  - MAIN_GREEN holds regardless of pending requests.
  - SIDE_GREEN and PED_WALK are truncated: the next state is SIDE_YELLOW or ALL_RED_M respectively. Pending flags are unaffected except as served on entry.
  - Yellow and all-red states run to completion.
- After emerg drops, normal sequencing resumes.

Not defined:
- No `emerg` port and no preemption logic.

Test Plan:
1. Reset 3 cycles, release, no requests -> phase=0 for 1 cycle, then phase=1 held for 100 cycles; main_green=1, side_red=1, ped_ack never pulses.
2. side_sensor pulse on cycle 5 of MAIN_GREEN -> MAIN_GREEN lasts 20 cycles, yellow 3, all-red 1, SIDE_GREEN 10, SIDE_YELLOW 3, ALL_RED_M 1, then MAIN_GREEN holds.
3. ped_req pulse after main-green expiry -> MAIN_YELLOW next cycle, then yellow 3, all-red 1, walk=1 for 8 cycles, ped_ack high on walk cycle 1 only, then ALL_RED_M → MAIN_GREEN; no SIDE_GREEN.
4. side_sensor and ped_req both asserted in MAIN_GREEN -> PED_WALK (8 cycles) then SIDE_GREEN (10 cycles); both pend flags clear; a second ped_req during SIDE_GREEN is served in the next rotation.
5. rst asserted on cycle 4 of SIDE_GREEN -> next cycle phase=0 with main_red=side_red=1; after release, MAIN_GREEN holds (side_pend cleared).
6. (EMERGENCY_PREEMPT_EN) emerg=1 on cycle 2 of SIDE_GREEN -> SIDE_YELLOW next cycle (3 cycles), ALL_RED_M, then MAIN_GREEN held while emerg=1 despite side_pend=1.
